// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if
//   Bundles the controller-facing signals of the convolution sequencer.
//   master : controller side, drives en/state/config, observes flags/addresses.
//   slave  : sequencer side, consumes en/state/config, drives flags/addresses.
//   Inputs to the sequencer : en, state, cfg_we, cfg_taps, cfg_stages, cfg_vectors
//   Outputs of the sequencer: vector_pass, last_stage, last_vector, coef_addr,
//                             data_addr, mac_init, mac_acc, frame_start
interface conv_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int TAP_W   = 6,
  parameter int STAGE_W = 3,
  parameter int VEC_W   = 4
);
  logic               en;
  logic [2:0]         state;
  logic               cfg_we;
  logic [TAP_W-1:0]   cfg_taps;
  logic [STAGE_W-1:0] cfg_stages;
  logic [VEC_W-1:0]   cfg_vectors;
  logic               vector_pass;
  logic               last_stage;
  logic               last_vector;
  logic [ADDR_W-1:0]  coef_addr;
  logic [ADDR_W-1:0]  data_addr;
  logic               mac_init;
  logic               mac_acc;
  logic               frame_start;

  modport master (
    output en, state, cfg_we, cfg_taps, cfg_stages, cfg_vectors,
    input  vector_pass, last_stage, last_vector, coef_addr, data_addr,
           mac_init, mac_acc, frame_start
  );

  modport slave (
    input  en, state, cfg_we, cfg_taps, cfg_stages, cfg_vectors,
    output vector_pass, last_stage, last_vector, coef_addr, data_addr,
           mac_init, mac_acc, frame_start
  );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer
//   Address/flag sequencer for the upsampler MAC datapath. Counts taps within
//   a vector, walks the stage/vector allocation list, generates coefficient and
//   sample-history RAM addresses and MAC strobes, and holds a shadow copy of
//   the filter configuration that only changes at frame boundaries.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : conv_sequencer_if.slave (controller state/config in, flags out)
module conv_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TAP_W   = 6,
  parameter int STAGE_W = 3,
  parameter int VEC_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_sequencer_if.slave      bus
);

  localparam logic [2:0] S_ALLOC = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_LDIN  = 3'd6;
  localparam logic [2:0] S_PCINC = 3'd7;

  logic [TAP_W-1:0]   tap_cnt_q,   tap_cnt_d;
  logic [STAGE_W-1:0] stage_cnt_q, stage_cnt_d;
  logic [VEC_W-1:0]   vec_cnt_q,   vec_cnt_d;
  logic [ADDR_W-1:0]  coef_base_q, coef_base_d;
  logic [ADDR_W-1:0]  data_ptr_q,  data_ptr_d;
  logic [TAP_W-1:0]   taps_q,      taps_d;
  logic [STAGE_W-1:0] stages_q,    stages_d;
  logic [VEC_W-1:0]   vecs_q,      vecs_d;

  logic              frame_start;
  logic [ADDR_W-1:0] tap_ext;
  logic [ADDR_W-1:0] vec_stride;

  assign frame_start = (bus.state == S_ALLOC) && (stage_cnt_q == '0) && (vec_cnt_q == '0);
  assign tap_ext     = ADDR_W'(tap_cnt_q);
  // Each stage/vector slot owns taps_r+1 consecutive coefficients.
  assign vec_stride  = ADDR_W'(taps_q) + ADDR_W'(1);

  always_comb begin
    tap_cnt_d   = tap_cnt_q;
    stage_cnt_d = stage_cnt_q;
    vec_cnt_d   = vec_cnt_q;
    coef_base_d = coef_base_q;
    data_ptr_d  = data_ptr_q;
    taps_d      = taps_q;
    stages_d    = stages_q;
    vecs_d      = vecs_q;
    if (bus.en) begin
      case (bus.state)
        S_ALLOC: begin
          if (frame_start && bus.cfg_we) begin
            taps_d   = bus.cfg_taps;
            stages_d = bus.cfg_stages;
            vecs_d   = bus.cfg_vectors;
          end
        end
        S_INIT: tap_cnt_d = '0;
        // Saturate at the last tap so an FSM that lingers cannot wrap the address.
        S_CONV: if (tap_cnt_q != taps_q) tap_cnt_d = tap_cnt_q + TAP_W'(1);
        S_LDIN: data_ptr_d = data_ptr_q + ADDR_W'(1);
        S_PCINC: begin
          if (stage_cnt_q != stages_q) begin
            stage_cnt_d = stage_cnt_q + STAGE_W'(1);
            coef_base_d = coef_base_q + vec_stride;
          end else if (vec_cnt_q != vecs_q) begin
            stage_cnt_d = '0;
            vec_cnt_d   = vec_cnt_q + VEC_W'(1);
            coef_base_d = coef_base_q + vec_stride;
          end else begin
            stage_cnt_d = '0;
            vec_cnt_d   = '0;
            coef_base_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt_q   <= '0;
      stage_cnt_q <= '0;
      vec_cnt_q   <= '0;
      coef_base_q <= '0;
      data_ptr_q  <= '0;
      taps_q      <= '0;
      stages_q    <= '0;
      vecs_q      <= '0;
    end else begin
      tap_cnt_q   <= tap_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      coef_base_q <= coef_base_d;
      data_ptr_q  <= data_ptr_d;
      taps_q      <= taps_d;
      stages_q    <= stages_d;
      vecs_q      <= vecs_d;
    end
  end

  assign bus.vector_pass = (bus.state == S_CONV) && (tap_cnt_q == taps_q);
  assign bus.last_stage  = (stage_cnt_q == stages_q);
  assign bus.last_vector = (vec_cnt_q == vecs_q);
  assign bus.coef_addr   = coef_base_q + tap_ext;
  // History is read newest-first, so later taps reach further back.
  assign bus.data_addr   = data_ptr_q - tap_ext;
  assign bus.mac_init    = bus.en && (bus.state == S_INIT);
  assign bus.mac_acc     = bus.en && (bus.state == S_CONV);
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sequencer_if #(.ADDR_W(8), .TAP_W(6), .STAGE_W(3), .VEC_W(4)) bus ();
  conv_sequencer #(.ADDR_W(8), .TAP_W(6), .STAGE_W(3), .VEC_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic       vp, ls, lv;
    logic [7:0] coef, data;
    logic       init, acc, fs;
  } obs_t;

  obs_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: allocation walked as a single linear slot index; the
  // coefficient base is the slot number times the vector length.
  int m_tap, m_slot, m_ptr, m_taps, m_stages, m_vecs;

  task automatic model_reset();
    m_tap = 0; m_slot = 0; m_ptr = 0; m_taps = 0; m_stages = 0; m_vecs = 0;
  endtask

  function automatic obs_t model_out(input bit e, input int s);
    obs_t o;
    int s1;
    s1     = m_stages + 1;
    o.vp   = (s == 2) && (m_tap == m_taps);
    o.ls   = (m_slot % s1) == m_stages;
    o.lv   = (m_slot / s1) == m_vecs;
    o.coef = 8'((m_slot * (m_taps + 1) + m_tap) % 256);
    o.data = 8'(((m_ptr - m_tap) % 256 + 256) % 256);
    o.init = e && (s == 1);
    o.acc  = e && (s == 2);
    o.fs   = (s == 0) && (m_slot == 0);
    return o;
  endfunction

  task automatic model_update(input int s, input bit we, input int t, input int st, input int v);
    case (s)
      0: if (m_slot == 0 && we) begin m_taps = t; m_stages = st; m_vecs = v; end
      1: m_tap = 0;
      2: if (m_tap != m_taps) m_tap = (m_tap + 1) % 64;
      6: m_ptr = (m_ptr + 1) % 256;
      7: m_slot = (m_slot + 1) % ((m_stages + 1) * (m_vecs + 1));
      default: ;
    endcase
  endtask

  // One cycle of stimulus: drive, queue the expected response, advance model.
  task automatic step(input bit r, input bit e, input int s, input bit we,
                      input int t, input int st, input int v);
    rst = r;
    bus.en = e;
    bus.state = 3'(s);
    bus.cfg_we = we;
    bus.cfg_taps = 6'(t);
    bus.cfg_stages = 3'(st);
    bus.cfg_vectors = 4'(v);
    if (r) model_reset();
    exp_q.push_back(model_out(e, s));
    if (!r && e) model_update(s, we, t, st, v);
    @(posedge clk); #1;
  endtask

  task automatic go(input int s);
    step(0, 1, s, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int t, input int st, input int v);
    step(0, 1, 0, 1, t, st, v);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = '{bus.vector_pass, bus.last_stage, bus.last_vector, bus.coef_addr,
            bus.data_addr, bus.mac_init, bus.mac_acc, bus.frame_start};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs t=%0t got vp=%b ls=%b lv=%b coef=%0d data=%0d init=%b acc=%b fs=%b want vp=%b ls=%b lv=%b coef=%0d data=%0d init=%b acc=%b fs=%b",
                 $time, a.vp, a.ls, a.lv, a.coef, a.data, a.init, a.acc, a.fs,
                 e.vp, e.ls, e.lv, e.coef, e.data, e.init, e.acc, e.fs);
      end
    end
  end

  initial begin
    bus.en = 1'b0; bus.state = 3'd0; bus.cfg_we = 1'b0;
    bus.cfg_taps = '0; bus.cfg_stages = '0; bus.cfg_vectors = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    do_reset();

    // Tap counting with taps=3, including saturation on a 5th cycle
    cfg(3, 0, 0);
    go(1);
    repeat (5) go(2);

    // Reset mid-convolution at tap 5: outputs clear before the next edge
    do_reset();
    cfg(7, 0, 0);
    go(1);
    repeat (5) go(2);
    step(1, 1, 2, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);

    // Sample pointer wrap: ptr=2, taps=3 -> data 2,1,0,255
    step(0, 1, 0, 0, 0, 0, 0);
    cfg(3, 0, 0);
    go(6); go(6);
    go(1);
    repeat (4) go(2);

    // Full loops with stages=1, vectors=1, taps=3
    do_reset();
    cfg(3, 1, 1);
    repeat (5) begin
      go(1);
      repeat (4) go(2);
      go(3); go(4); go(5); go(6); go(7);
      go(0);
    end

    // Config write outside the frame window is ignored
    go(7);
    cfg(7, 0, 0);
    go(1);
    repeat (8) go(2);
    go(7); go(7); go(7);
    cfg(7, 0, 0);
    go(1);
    repeat (8) go(2);

    // Clock-enable freeze in CONVOLUTION
    go(1);
    go(2); go(2);
    repeat (3) step(0, 0, 2, 0, 0, 0, 0);
    repeat (3) go(2);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r, e, we;
      r  = ($urandom_range(0, 299) == 0);
      e  = ($urandom_range(0, 99) < 85);
      we = ($urandom_range(0, 3) == 0);
      step(r, e, $urandom_range(0, 7), we,
           $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15));
    end
    step(0, 0, 0, 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
